// File: rtl/parity_frame_ctrl.sv
// Serial frame deframer: start, DATA_W data bits LSB-first, parity, stop; valid/ready output.
// Optional error counter output errCount is built when PARITY_FRAME_ERRCNT_EN is defined.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a start bit (bitIn==0 strobe)
// DATA   | shifting in DATA_W data bits, running XOR in par
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit
// HOLD   | frame presented on frameValid until frameReady
module parity_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bitValid,
  input  logic              bitIn,
  output logic [DATA_W-1:0] frameData,
  output logic              frameValid,
  input  logic              frameReady,
  output logic              parityErr,
  output logic              framingErr,
  output logic              overrun,
  output logic              abortPulse
`ifdef PARITY_FRAME_ERRCNT_EN
  ,
  output logic [7:0]        errCount
`endif
);

  localparam int   CNT_W = $clog2(DATA_W + 1);
  localparam int   TMR_W = $clog2(TIMEOUT + 1);
  localparam logic ODD   = (ODD_PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_HOLD
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              par, par_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              perr_nxt, ferr_nxt, fvalid_nxt, ovr_nxt, abort_nxt;
  logic              in_frame, timed_out, accept;

  assign in_frame  = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
  assign timed_out = in_frame && (timer == '0);
  assign accept    = (state == S_HOLD) && frameValid && frameReady;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    par_nxt    = par;
    timer_nxt  = TMR_W'(TIMEOUT);
    data_nxt   = frameData;
    perr_nxt   = parityErr;
    ferr_nxt   = framingErr;
    fvalid_nxt = frameValid;
    ovr_nxt    = overrun;
    abort_nxt  = 1'b0;

    if (timed_out) begin
      // a strobe landing in the timeout cycle is deliberately ignored
      state_nxt = S_IDLE;
      abort_nxt = 1'b1;
    end else if (in_frame && !bitValid) begin
      timer_nxt = timer - 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bitValid && !bitIn) begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
            par_nxt   = 1'b0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CNT_W'(i)) data_nxt[i] = bitIn;
          end
          par_nxt = par ^ bitIn;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          // par now carries the pending parity error; it is only published
          // with the stop bit so an aborted frame never disturbs the flags
          par_nxt   = ((par ^ bitIn) != ODD);
          state_nxt = S_STOP;
        end
        S_STOP: begin
          perr_nxt   = par;
          ferr_nxt   = ~bitIn;
          fvalid_nxt = 1'b1;
          state_nxt  = S_HOLD;
        end
        S_HOLD: begin
          if (bitValid && !bitIn) ovr_nxt = 1'b1;
          if (accept) begin
            fvalid_nxt = 1'b0;
            perr_nxt   = 1'b0;
            ferr_nxt   = 1'b0;
            state_nxt  = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      par        <= 1'b0;
      timer      <= '0;
      frameData  <= '0;
      parityErr  <= 1'b0;
      framingErr <= 1'b0;
      frameValid <= 1'b0;
      overrun    <= 1'b0;
      abortPulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      par        <= par_nxt;
      timer      <= timer_nxt;
      frameData  <= data_nxt;
      parityErr  <= perr_nxt;
      framingErr <= ferr_nxt;
      frameValid <= fvalid_nxt;
      overrun    <= ovr_nxt;
      abortPulse <= abort_nxt;
    end
  end

`ifdef PARITY_FRAME_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && (parityErr || framingErr) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign errCount = err_cnt;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench for parity_frame_ctrl: even-parity and odd-parity instances share one bit stream.
// Error-counter checks are compiled when PARITY_FRAME_ERRCNT_EN is defined.
module tb_parity_frame_ctrl;

  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct {
    bit            is_abort;
    logic [DW-1:0] data;
    bit            pbit;
    bit            sbit;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst, bitValid, bitIn, frameReady;
  logic [DW-1:0] fd [2];
  logic          fv [2], pe [2], fe [2], ov [2], ab [2];
`ifdef PARITY_FRAME_ERRCNT_EN
  logic [7:0]    ec [2];
`endif

  int  n_chk = 0;
  int  n_fail = 0;
  int  rdy_mode = 1;
  ev_t evq[$];
  int  rd [2] = '{0, 0};
  int  bad [2] = '{0, 0};

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(0), .TIMEOUT(TO)) u_even (
    .clk(clk), .rst(rst), .bitValid(bitValid), .bitIn(bitIn),
    .frameData(fd[0]), .frameValid(fv[0]), .frameReady(frameReady),
    .parityErr(pe[0]), .framingErr(fe[0]), .overrun(ov[0]), .abortPulse(ab[0])
`ifdef PARITY_FRAME_ERRCNT_EN
    , .errCount(ec[0])
`endif
  );

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(1), .TIMEOUT(TO)) u_odd (
    .clk(clk), .rst(rst), .bitValid(bitValid), .bitIn(bitIn),
    .frameData(fd[1]), .frameValid(fv[1]), .frameReady(frameReady),
    .parityErr(pe[1]), .framingErr(fe[1]), .overrun(ov[1]), .abortPulse(ab[1])
`ifdef PARITY_FRAME_ERRCNT_EN
    , .errCount(ec[1])
`endif
  );

  task automatic check_b(input string name, input int d, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // dut d uses odd parity when d==1; error when total ones count has the wrong parity
  function automatic bit exp_perr(input logic [DW-1:0] data, input bit pbit, input int d);
    int ones;
    ones = $countones(data) + int'(pbit);
    return (ones % 2) != d;
  endfunction

  function automatic int rgap(input int lo, input int hi);
    return lo + int'($urandom % 32'(hi - lo + 1));
  endfunction

  initial begin
    frameReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      frameReady = (rdy_mode == 2) ? (($urandom % 2) == 1) : (rdy_mode == 1);
    end
  end

  // monitor: pops the scoreboard whenever a DUT accepts a frame or aborts
  logic          fv_p [2], rdy_p, ab_p [2], pe_p [2], fe_p [2];
  logic [DW-1:0] fd_p [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        if (ab[d]) begin
          if (rd[d] < evq.size()) begin
            if (evq[rd[d]].is_abort) check_b("abort_width", d, ab_p[d], 1'b0);
            else check_b("abort_instead_of_frame", d, ab[d], 1'b0);
            rd[d]++;
          end else begin
            check_b("unexpected_abort", d, ab[d], 1'b0);
          end
        end
        if (fv[d] && fv_p[d] && !rdy_p) begin
          check_w("hold_data_stable", d, 32'(fd[d]), 32'(fd_p[d]));
          check_b("hold_perr_stable", d, pe[d], pe_p[d]);
          check_b("hold_ferr_stable", d, fe[d], fe_p[d]);
        end
        if (fv[d] && frameReady) begin
          if (rd[d] < evq.size()) begin
            if (evq[rd[d]].is_abort) begin
              check_b("frame_instead_of_abort", d, ab[d], 1'b1);
            end else begin
              check_w("frame_data", d, 32'(fd[d]), 32'(evq[rd[d]].data));
              check_b("parity_err", d, pe[d], exp_perr(evq[rd[d]].data, evq[rd[d]].pbit, d));
              check_b("framing_err", d, fe[d], !evq[rd[d]].sbit);
              if (exp_perr(evq[rd[d]].data, evq[rd[d]].pbit, d) || !evq[rd[d]].sbit) bad[d]++;
            end
            rd[d]++;
          end else begin
            check_b("unexpected_frame", d, fv[d], 1'b0);
          end
        end
      end
      fv_p[d] = rst ? 1'b0 : fv[d];
      ab_p[d] = rst ? 1'b0 : ab[d];
      fd_p[d] = fd[d];
      pe_p[d] = pe[d];
      fe_p[d] = fe[d];
    end
    rdy_p = frameReady;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // gap = idle cycles before this strobe; returns 1 ns after the capturing edge
  task automatic strobe(input bit b, input int gap);
    repeat (gap) cycle();
    bitValid = 1'b1;
    bitIn    = b;
    cycle();
    bitValid = 1'b0;
    bitIn    = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input bit pbit, input bit sbit,
                            input int glo, input int ghi);
    ev_t e;
    e.is_abort = 1'b0;
    e.data     = data;
    e.pbit     = pbit;
    e.sbit     = sbit;
    evq.push_back(e);
    repeat ($urandom % 3) strobe(1'b1, rgap(0, 2));
    strobe(1'b0, rgap(0, 2));
    for (int i = 0; i < DW; i++) strobe(data[i], rgap(glo, ghi));
    strobe(pbit, rgap(glo, ghi));
    strobe(sbit, rgap(glo, ghi));
    for (int d = 0; d < 2; d++) check_b("valid_after_stop", d, fv[d], 1'b1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (!(rd[0] == evq.size() && rd[1] == evq.size()) && i < 400) begin
      cycle();
      i++;
    end
    check_b("drain_in_budget", 0, (rd[0] == evq.size() && rd[1] == evq.size()), 1'b1);
  endtask

  initial begin
    logic [DW-1:0] dat;
    rst      = 1'b1;
    bitValid = 1'b0;
    bitIn    = 1'b1;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      check_w("reset_data", d, 32'(fd[d]), 32'h0);
      check_b("reset_valid", d, fv[d], 1'b0);
      check_b("reset_perr", d, pe[d], 1'b0);
      check_b("reset_ferr", d, fe[d], 1'b0);
      check_b("reset_overrun", d, ov[d], 1'b0);
      check_b("reset_abort", d, ab[d], 1'b0);
    end
    rst = 1'b0;
    cycle();

    send_frame(8'h05, 1'b0, 1'b1, 0, 0); drain();
    send_frame(8'h05, 1'b1, 1'b1, 0, 0); drain();
    send_frame(8'h05, 1'b0, 1'b0, 0, 0); drain();
    send_frame(8'hFF, 1'b1, 1'b1, 0, 0); drain();
    dat = 8'($urandom);
    send_frame(dat, 1'($urandom), 1'b1, TO - 1, TO - 1); drain();

    // consumer stalls; a start bit during HOLD must be dropped and flagged
    rdy_mode = 0;
    cycle();
    send_frame(8'hA6, 1'b0, 1'b1, 0, 1);
    repeat (20) cycle();
    for (int d = 0; d < 2; d++) check_b("overrun_before", d, ov[d], 1'b0);
    strobe(1'b0, 0);
    for (int d = 0; d < 2; d++) begin
      check_b("overrun_set", d, ov[d], 1'b1);
      check_b("held_valid", d, fv[d], 1'b1);
      check_w("held_data", d, 32'(fd[d]), 32'hA6);
    end
    rdy_mode = 1;
    drain();
    cycle();
    for (int d = 0; d < 2; d++) begin
      check_b("valid_falls", d, fv[d], 1'b0);
      check_b("overrun_sticky", d, ov[d], 1'b1);
    end
    send_frame(8'h5A, 1'b1, 1'b1, 0, 3); drain();

    // timeout: start + 3 data bits, then a strobe exactly in the timeout cycle
    begin
      ev_t e;
      e.is_abort = 1'b1;
      e.data     = '0;
      e.pbit     = 1'b0;
      e.sbit     = 1'b0;
      evq.push_back(e);
    end
    strobe(1'b0, 0);
    repeat (3) strobe(1'($urandom), rgap(0, TO - 1));
    strobe(1'b1, TO);
    for (int d = 0; d < 2; d++) begin
      check_b("abort_pulse", d, ab[d], 1'b1);
      check_b("abort_no_valid", d, fv[d], 1'b0);
    end
    drain();
    repeat (3) cycle();
    send_frame(8'h3C, 1'b0, 1'b1, 0, 2); drain();

    // synchronous reset in the middle of DATA
    strobe(1'b0, 0);
    repeat (3) strobe(1'($urandom), 0);
    rst = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++) begin
      check_w("rst_mid_data", d, 32'(fd[d]), 32'h0);
      check_b("rst_mid_valid", d, fv[d], 1'b0);
      check_b("rst_mid_overrun", d, ov[d], 1'b0);
      check_b("rst_mid_abort", d, ab[d], 1'b0);
    end
    rst = 1'b0;
    bad[0] = 0;
    bad[1] = 0;
    cycle();
    send_frame(8'h96, 1'b0, 1'b1, 0, 2); drain();

    rdy_mode = 2;
    repeat (40) begin
      dat = 8'($urandom);
      send_frame(dat, 1'($urandom), (($urandom % 4) != 0), 0, TO - 1);
      drain();
    end

`ifdef PARITY_FRAME_ERRCNT_EN
    rdy_mode = 1;
    repeat (300) begin
      dat = 8'($urandom);
      send_frame(dat, 1'($urandom), 1'b0, 0, 0);
      drain();
    end
    cycle();
    for (int d = 0; d < 2; d++)
      check_w("err_count", d, 32'(ec[d]), (bad[d] > 255) ? 32'd255 : 32'(bad[d]));
`endif

    repeat (4) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
